// File: rtl/serial_pattern_pkg.sv
// Shared types and default parameters for the serial pattern generator.
package serial_pattern_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEF_MAX_LEN    = 16;
   localparam int DEF_CNT_W      = 8;
   localparam int DEF_GAP_CYCLES = 0;

endpackage

// File: rtl/serial_pattern_gen_if.sv
// Request/serial-output bundle of the pattern generator; the requester is the master.
interface serial_pattern_gen_if
   import serial_pattern_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int CNT_W   = DEF_CNT_W
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   logic               pat_valid;
   logic               pat_ready;
   logic [MAX_LEN-1:0] pat_data;
   logic [LEN_W-1:0]   pat_len;
   logic [CNT_W-1:0]   pat_repeat;
   logic               abort;
   logic               dout;
   logic               dout_valid;
   logic               frame_start;
   logic               done;
   logic               err;
   logic               busy;

   modport master (
      output pat_valid, pat_data, pat_len, pat_repeat, abort,
      input  pat_ready, dout, dout_valid, frame_start, done, err, busy
   );

   modport slave (
      input  pat_valid, pat_data, pat_len, pat_repeat, abort,
      output pat_ready, dout, dout_valid, frame_start, done, err, busy
   );

endinterface

// File: rtl/serial_pattern_gen.sv
// Serial bit-pattern generator: sends a latched pattern MSB-first, repeated,
// with optional idle gaps between repetitions. All outputs are flops.
module serial_pattern_gen
   import serial_pattern_pkg::*;
#(
   parameter int MAX_LEN    = DEF_MAX_LEN,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES
)(
   input  logic              clk,
   input  logic              rst_n,
   serial_pattern_gen_if.slave bus
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   state_t             state_r, state_nxt_s;
   logic [MAX_LEN-1:0] shreg_r, shreg_nxt_s, shifted_s;
   logic [LEN_W-1:0]   len_r, len_nxt_s;
   logic [LEN_W-1:0]   bit_idx_r, bit_idx_nxt_s;
   logic [CNT_W-1:0]   rep_r, rep_nxt_s;
   logic               err_flag_r, err_flag_nxt_s;
   logic [GAP_W-1:0]   gap_cnt_r;
   logic               len_ok_s;
   logic               dout_r, dout_valid_r, frame_start_r, done_r, err_r, busy_r, pat_ready_r;
   logic               dout_nxt_s, dout_valid_nxt_s, frame_start_nxt_s, done_nxt_s, err_nxt_s;

   assign len_ok_s = (bus.pat_len != {LEN_W{1'b0}}) && (bus.pat_len <= LEN_W'(MAX_LEN));

   // State and job registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         shreg_r    <= '0;
         len_r      <= '0;
         bit_idx_r  <= '0;
         rep_r      <= '0;
         err_flag_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         shreg_r    <= shreg_nxt_s;
         len_r      <= len_nxt_s;
         bit_idx_r  <= bit_idx_nxt_s;
         rep_r      <= rep_nxt_s;
         err_flag_r <= err_flag_nxt_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.pat_valid) state_nxt_s = len_ok_s ? SHIFT : DONE;
            else               state_nxt_s = IDLE;
         end
         SHIFT: begin
            if (bus.abort)                       state_nxt_s = IDLE;
            else if (bit_idx_r != {LEN_W{1'b0}}) state_nxt_s = SHIFT;
            else if (rep_r == {CNT_W{1'b0}})     state_nxt_s = DONE;
            else if (GAP_CYCLES > 0)             state_nxt_s = GAP;
            else                                 state_nxt_s = SHIFT;
         end
         GAP: begin
            if (bus.abort)                       state_nxt_s = IDLE;
            else if (gap_cnt_r == {GAP_W{1'b0}}) state_nxt_s = SHIFT;
            else                                 state_nxt_s = GAP;
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Capture and counter updates; the repeat counter is tested for zero before it decrements
   always_comb begin
      shreg_nxt_s    = shreg_r;
      len_nxt_s      = len_r;
      bit_idx_nxt_s  = bit_idx_r;
      rep_nxt_s      = rep_r;
      err_flag_nxt_s = err_flag_r;
      case (state_r)
         IDLE: begin
            if (bus.pat_valid) begin
               shreg_nxt_s    = bus.pat_data;
               len_nxt_s      = bus.pat_len;
               rep_nxt_s      = bus.pat_repeat;
               err_flag_nxt_s = !len_ok_s;
               if (len_ok_s) bit_idx_nxt_s = bus.pat_len - LEN_W'(1);
               else          bit_idx_nxt_s = bit_idx_r;
            end else begin
               err_flag_nxt_s = err_flag_r;
            end
         end
         SHIFT: begin
            if (bit_idx_r != {LEN_W{1'b0}}) begin
               bit_idx_nxt_s = bit_idx_r - LEN_W'(1);
            end else if (rep_r != {CNT_W{1'b0}}) begin
               rep_nxt_s     = rep_r - CNT_W'(1);
               bit_idx_nxt_s = len_r - LEN_W'(1);
            end else begin
               bit_idx_nxt_s = bit_idx_r;
            end
         end
         default: begin
            bit_idx_nxt_s = bit_idx_r;
         end
      endcase
   end

   if (GAP_CYCLES > 0) begin : g_gap
      // Gap counter: loaded on SHIFT->GAP, counts down to the restart of SHIFT
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            gap_cnt_r <= '0;
         else if (state_r == SHIFT && state_nxt_s == GAP)
            gap_cnt_r <= GAP_W'(GAP_CYCLES - 1);
         else if (state_r == GAP && gap_cnt_r != {GAP_W{1'b0}})
            gap_cnt_r <= gap_cnt_r - GAP_W'(1);
         else
            gap_cnt_r <= gap_cnt_r;
      end
   end else begin : g_no_gap
      assign gap_cnt_r = '0;
   end

   // Output decode from the next state so the registered outputs line up with it
   always_comb begin
      shifted_s         = shreg_nxt_s >> bit_idx_nxt_s;
      dout_nxt_s        = 1'b0;
      dout_valid_nxt_s  = 1'b0;
      frame_start_nxt_s = 1'b0;
      done_nxt_s        = 1'b0;
      err_nxt_s         = 1'b0;
      case (state_nxt_s)
         SHIFT: begin
            dout_nxt_s        = shifted_s[0];
            dout_valid_nxt_s  = 1'b1;
            frame_start_nxt_s = (bit_idx_nxt_s == len_nxt_s - LEN_W'(1));
         end
         DONE: begin
            done_nxt_s = !err_flag_nxt_s;
            err_nxt_s  = err_flag_nxt_s;
         end
         default: begin
            dout_nxt_s = 1'b0;
         end
      endcase
   end

   // Registered output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_r        <= 1'b0;
         dout_valid_r  <= 1'b0;
         frame_start_r <= 1'b0;
         done_r        <= 1'b0;
         err_r         <= 1'b0;
         busy_r        <= 1'b0;
         pat_ready_r   <= 1'b1;
      end else begin
         dout_r        <= dout_nxt_s;
         dout_valid_r  <= dout_valid_nxt_s;
         frame_start_r <= frame_start_nxt_s;
         done_r        <= done_nxt_s;
         err_r         <= err_nxt_s;
         busy_r        <= (state_nxt_s != IDLE);
         pat_ready_r   <= (state_nxt_s == IDLE);
      end
   end

   assign bus.dout        = dout_r;
   assign bus.dout_valid  = dout_valid_r;
   assign bus.frame_start = frame_start_r;
   assign bus.done        = done_r;
   assign bus.err         = err_r;
   assign bus.busy        = busy_r;
   assign bus.pat_ready   = pat_ready_r;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen: one instance back-to-back, one with a 2-cycle gap.
module tb_serial_pattern_gen;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_mis = 0;
   logic [31:0] cap_dv, cap_d, cap_fs, cap_done, cap_err, cap_rdy;

   serial_pattern_gen_if #(.MAX_LEN(16), .CNT_W(8)) bus0 ();
   serial_pattern_gen_if #(.MAX_LEN(16), .CNT_W(8)) bus1 ();

   serial_pattern_gen #(.MAX_LEN(16), .CNT_W(8), .GAP_CYCLES(0)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus0)
   );
   serial_pattern_gen #(.MAX_LEN(16), .CNT_W(8), .GAP_CYCLES(2)) dut_gap (
      .clk(clk), .rst_n(rst_n), .bus(bus1)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int which, input logic v, input logic [15:0] data,
                          input logic [4:0] len, input logic [7:0] rep, input logic ab);
      if (which == 0) begin
         bus0.pat_valid = v; bus0.pat_data = data; bus0.pat_len = len;
         bus0.pat_repeat = rep; bus0.abort = ab;
      end else begin
         bus1.pat_valid = v; bus1.pat_data = data; bus1.pat_len = len;
         bus1.pat_repeat = rep; bus1.abort = ab;
      end
   endtask

   // Shift one cycle of outputs into the capture vectors (first cycle ends up leftmost)
   task automatic sample(input int which);
      if (which == 0) begin
         cap_dv   = {cap_dv[30:0],   bus0.dout_valid};
         cap_d    = {cap_d[30:0],    bus0.dout};
         cap_fs   = {cap_fs[30:0],   bus0.frame_start};
         cap_done = {cap_done[30:0], bus0.done};
         cap_err  = {cap_err[30:0],  bus0.err};
         cap_rdy  = {cap_rdy[30:0],  bus0.pat_ready};
      end else begin
         cap_dv   = {cap_dv[30:0],   bus1.dout_valid};
         cap_d    = {cap_d[30:0],    bus1.dout};
         cap_fs   = {cap_fs[30:0],   bus1.frame_start};
         cap_done = {cap_done[30:0], bus1.done};
         cap_err  = {cap_err[30:0],  bus1.err};
         cap_rdy  = {cap_rdy[30:0],  bus1.pat_ready};
      end
   endtask

   task automatic clear_caps();
      cap_dv = '0; cap_d = '0; cap_fs = '0; cap_done = '0; cap_err = '0; cap_rdy = '0;
   endtask

   // Offer one job, then record cycles T+1..T+ncyc; abort is raised during cycle abort_at
   task automatic run_job(input int which, input logic [15:0] data, input logic [4:0] len,
                          input logic [7:0] rep, input int ncyc, input int abort_at);
      clear_caps();
      @(negedge clk);
      set_req(which, 1'b1, data, len, rep, 1'b0);
      check_val("ready_before_accept",
                32'(which == 0 ? bus0.pat_ready : bus1.pat_ready), 32'd1);
      @(posedge clk);
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         sample(which);
         set_req(which, 1'b0, 16'h0000, 5'd0, 8'd0, k == abort_at);
      end
      set_req(which, 1'b0, 16'h0000, 5'd0, 8'd0, 1'b0);
   endtask

   task automatic check_run(input string tag, input logic [31:0] e_dv, input logic [31:0] e_d,
                            input logic [31:0] e_fs, input logic [31:0] e_done,
                            input logic [31:0] e_err, input logic [31:0] e_rdy);
      check_val({tag, "_dout_valid"},  cap_dv,   e_dv);
      check_val({tag, "_dout"},        cap_d,    e_d);
      check_val({tag, "_frame_start"}, cap_fs,   e_fs);
      check_val({tag, "_done"},        cap_done, e_done);
      check_val({tag, "_err"},         cap_err,  e_err);
      check_val({tag, "_pat_ready"},   cap_rdy,  e_rdy);
   endtask

   initial begin
      // Reset with random inputs on both instances
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_req(0, 1'($urandom), 16'($urandom), 5'($urandom), 8'($urandom), 1'($urandom));
         set_req(1, 1'($urandom), 16'($urandom), 5'($urandom), 8'($urandom), 1'($urandom));
         @(negedge clk);
      end
      check_val("rst_dout",        32'(bus0.dout),        32'd0);
      check_val("rst_dout_valid",  32'(bus0.dout_valid),  32'd0);
      check_val("rst_frame_start", 32'(bus0.frame_start), 32'd0);
      check_val("rst_done",        32'(bus0.done),        32'd0);
      check_val("rst_err",         32'(bus0.err),         32'd0);
      check_val("rst_busy",        32'(bus0.busy),        32'd0);
      check_val("rst_pat_ready",   32'(bus0.pat_ready),   32'd1);
      check_val("rst_gap_ready",   32'(bus1.pat_ready),   32'd1);
      set_req(0, 1'b0, 16'h0000, 5'd0, 8'd0, 1'b0);
      set_req(1, 1'b0, 16'h0000, 5'd0, 8'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      clear_caps();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         sample(0);
      end
      check_run("idle", 32'b0, 32'b0, 32'b0, 32'b0, 32'b0, 32'b1111);

      // 101, single transmission
      run_job(0, 16'h0005, 5'd3, 8'd0, 6, 0);
      check_run("basic", 32'b111000, 32'b101000, 32'b100000, 32'b000100, 32'b0, 32'b000011);

      // 101 twice with a 2-cycle gap
      run_job(1, 16'h0005, 5'd3, 8'd1, 10, 0);
      check_run("gap2", 32'b1110011100, 32'b1010010100, 32'b1000010000,
                32'b0000000010, 32'b0, 32'b0000000001);

      // 101 twice back-to-back
      run_job(0, 16'h0005, 5'd3, 8'd1, 8, 0);
      check_run("gap0", 32'b11111100, 32'b10110100, 32'b10010000,
                32'b00000010, 32'b0, 32'b00000001);

      // Illegal lengths
      run_job(0, 16'hFFFF, 5'd0, 8'd3, 4, 0);
      check_run("len0", 32'b0, 32'b0, 32'b0, 32'b0, 32'b1000, 32'b0111);
      run_job(0, 16'hFFFF, 5'd17, 8'd0, 4, 0);
      check_run("len17", 32'b0, 32'b0, 32'b0, 32'b0, 32'b1000, 32'b0111);

      // Abort during the second bit of the second repetition (011 011 ...)
      run_job(0, 16'hA5C3, 5'd3, 8'd2, 8, 5);
      check_run("abort", 32'b11111000, 32'b01101000, 32'b10010000,
                32'b0, 32'b0, 32'b00000111);
      run_job(0, 16'h0005, 5'd3, 8'd0, 6, 0);
      check_run("after_abort", 32'b111000, 32'b101000, 32'b100000, 32'b000100, 32'b0, 32'b000011);

      // Full-width pattern
      run_job(0, 16'hA5C3, 5'd16, 8'd0, 18, 0);
      check_run("len16", 32'b111111111111111100, 32'b101001011100001100,
                32'b100000000000000000, 32'b000000000000000010, 32'b0,
                32'b000000000000000001);

      // Asynchronous reset mid-stream
      run_job(0, 16'hA5C3, 5'd16, 8'd0, 8, 0);
      check_val("mid_dout_stream", cap_d,  32'b10100101);
      check_val("mid_dv_stream",   cap_dv, 32'b11111111);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_dout",       32'(bus0.dout),       32'd0);
      check_val("arst_dout_valid", 32'(bus0.dout_valid), 32'd0);
      check_val("arst_busy",       32'(bus0.busy),       32'd0);
      check_val("arst_pat_ready",  32'(bus0.pat_ready),  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      clear_caps();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         sample(0);
      end
      check_val("post_arst_dv", cap_dv, 32'b0);
      run_job(0, 16'h0005, 5'd3, 8'd0, 6, 0);
      check_run("post_arst", 32'b111000, 32'b101000, 32'b100000, 32'b000100, 32'b0, 32'b000011);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/serial_pattern_gen.md
# serial_pattern_gen

Serial bit-pattern generator: accepts a pattern word, bit length and repeat count over a valid/ready handshake, then drives it MSB-first, one bit per clock, on a serial output. It is the stimulus/transmit side for the team's serial sequence detectors. A detector instance can be fed directly from `dout`/`dout_valid`. Single clock domain, fully registered outputs, Mealy-free (outputs depend on state only).

## Interface
- `MAX_LEN`, 16: maximum pattern length in bits (≥2).
- `LEN_W`, `$clog2(MAX_LEN+1)`: width of `pat_len`.
- `CNT_W`, 8: width of `pat_repeat`.
- `GAP_CYCLES`, 0: idle cycles inserted between repetitions (0 = back-to-back).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pat_valid`  in  1  pattern request.
- `pat_ready`  out  1  high only in IDLE.
- `pat_data`  in  MAX_LEN  pattern; bit `pat_len-1` is sent first, bit 0 last.
- `pat_len`  in  LEN_W  bits per repetition; legal range 1..MAX_LEN.
- `pat_repeat`  in  CNT_W  extra repetitions; total transmissions = `pat_repeat+1`.
- `abort`  in  1  synchronous cancel of the current job.
- `dout`  out  1  serial data; 0 whenever `dout_valid`=0.
- `dout_valid`  out  1  `dout` carries a pattern bit this cycle.
- `frame_start`  out  1  one-cycle pulse coincident with the first bit of each repetition.
- `done`  out  1  one-cycle pulse after a completed job.
- `err`  out  1  one-cycle pulse after an illegal `pat_len` is accepted.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SHIFT, GAP, DONE.
- IDLE: `pat_ready`=1. On `pat_valid`, latch `pat_data`, `pat_len` and `pat_repeat`.
  - If `pat_len` is legal, load the bit index with `pat_len-1` and the repeat counter with `pat_repeat`, then go to SHIFT.
  - Otherwise go to DONE with the error flag set.
- SHIFT: `dout`=`shreg[bit_idx]`, `dout_valid`=1. `frame_start`=1 when `bit_idx`=`len-1`. `bit_idx` decrements each cycle. At `bit_idx`=0:
  - If the repeat counter is 0, go to DONE.
  - Otherwise decrement the repeat counter and reload `bit_idx`=`len-1`. Go to GAP if `GAP_CYCLES`>0, else stay in SHIFT with no bubble.
- GAP: `dout_valid`=0 for exactly `GAP_CYCLES` cycles, then SHIFT.
- DONE: one cycle. Pulse `done` (legal job) or `err` (illegal length, no bits sent; `done` stays 0). Then go to IDLE.
- `abort` in SHIFT or GAP: next cycle is IDLE, `dout_valid`=0, and neither `done` nor `err` pulses. `abort` in IDLE or DONE is ignored.
- `abort` and `pat_valid` together in IDLE: the pattern is accepted.
- Latched fields do not change during a job. Input changes while `busy` is high have no effect.
- Counters use unsigned arithmetic. `bit_idx` is LEN_W wide. The repeat counter is CNT_W wide and never wraps, because it is checked for 0 before decrementing.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `frame_start`=0, `done`=0, `err`=0, `busy`=0, `pat_ready`=1, state=IDLE.
- `rst_n` asserted mid-job takes effect immediately and asynchronously. All outputs go to their reset values and the job is discarded.
- Let T be the accept edge (`pat_valid`&`pat_ready`). The first bit is on `dout` in cycle T+1.
- Job length N = len·(repeat+1) + GAP_CYCLES·repeat cycles.
- The last bit is in cycle T+N. `done` is in cycle T+N+1. `pat_ready` rises in cycle T+N+2.
- Illegal length: `err` in cycle T+1, `pat_ready` in cycle T+2.
- Minimum spacing between accepts: N+2 cycles.
- All outputs come from registers or a state decode. There is no combinational path from inputs to outputs.

## Structure
- Package `serial_pattern_pkg`:
  - `state_t` enum (IDLE, SHIFT, GAP, DONE, 2 bits).
  - Default-parameter localparams.
- Single module, no sub-module. Contents:
  - pattern/length/repeat capture registers;
  - `bit_idx` down-counter;
  - repeat down-counter;
  - gap counter (`$clog2(GAP_CYCLES+1)` bits, elided when `GAP_CYCLES`=0);
  - FSM;
  - registered output stage.

## Test plan
- Reset: hold `rst_n`=0 with random inputs. All outputs take their reset values and `pat_ready`=1. Release; there is no output activity until an accept.
- `pat_data`=16'h0005, len=3, repeat=0, accept at T. `dout`=1,0,1 in T+1..T+3 with `dout_valid`=1. `frame_start` at T+1, `done` at T+4, `pat_ready` at T+5.
- Same pattern with repeat=1 and `GAP_CYCLES`=2. Output is 101, two invalid cycles, then 101. `frame_start` at T+1 and T+6, `done` at T+9. Repeat with `GAP_CYCLES`=0: output is 101101 contiguous.
- len=0, then len=17 (MAX_LEN=16). `err` at T+1, `dout_valid` never high, `done` never high, `pat_ready` at T+2.
- `pat_data`=16'hA5C3, len=3, repeat=2. Assert `abort` during the second bit of the second repetition. `dout_valid`=0 on the next cycle, no `done`, `pat_ready`=1 on the next cycle. A new job is then accepted cleanly.
- len=16 with `pat_data`=16'hA5C3: the exact MSB-first stream is 1010010111000011. Also assert `rst_n` low mid-stream: outputs clear immediately.
